dds_sweep_ctrl: RTL and testbench

Frequency-sweep scheduler that sits in front of the DDS core's register write port. It steps the DDS frequency register from a start value by a fixed increment, holding each frequency for a programmed dwell time. It also shares the single DDS write port with a host register path, giving the host priority with a bounded delay for sweep writes.

---
 rtl/dds_sweep_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: frequency-sweep scheduler in front of the DDS register
// write port. Steps a frequency word from f_start by f_step, holding each
// value for a programmed dwell, and shares the single DDS write port with a
// host register path (host first, sweep deferred by at most one cycle).
//
// Optional feature: define DDS_SWEEP_LOOP_EN to make the sweep repeat from
// f_start after every pass until stop (done pulses once per pass).
//
// Port handshake: the host presents host_wr/host_waddr/host_wdata; the write
// is taken on a rising edge where host_wr && host_ready, and it appears on
// wr/waddr/wdata in the following cycle. While host_ready is low the host
// keeps its request and its address/data stable.
module dds_sweep_ctrl #(
    parameter logic [15:0] FREQ_ADDR = 16'h0020,
    parameter int          DATA_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [DATA_W-1:0] f_start,
    input  logic [DATA_W-1:0] f_step,
    input  logic [15:0]       n_steps,
    input  logic [15:0]       dwell,
    input  logic              host_wr,
    input  logic [15:0]       host_waddr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ready,
    output logic              wr,
    output logic [15:0]       waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] cur_freq
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DWELL = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   freq_q, freq_d;
    logic [DATA_W-1:0]   f_start_q, f_start_d;
    logic [DATA_W-1:0]   f_step_q, f_step_d;
    logic [DATA_W-1:0]   cur_freq_q, cur_freq_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [15:0]         n_steps_q, n_steps_d;
    logic [15:0]         step_cnt_q, step_cnt_d;
    logic [15:0]         dwell_q, dwell_d;
    logic [15:0]         dwell_cnt_q, dwell_cnt_d;
    logic [15:0]         waddr_q, waddr_d;
    logic                wr_q, wr_d;
    logic                done_q, done_d;
    logic                defer_q, defer_d;

    logic                sweep_req;
    logic                sweep_grant;
    logic                host_grant;
    logic                last_step;

    // Port arbitration: host wins unless the sweep was already held off once.
    always_comb begin
        sweep_req   = (state_q == S_WRITE) && !stop;
        host_ready  = !(sweep_req && defer_q);
        host_grant  = host_wr && host_ready;
        sweep_grant = sweep_req && (!host_wr || defer_q);
        last_step   = (step_cnt_q == (n_steps_q - 16'd1));
    end

    // Next-state, sweep bookkeeping and write-port output selection.
    always_comb begin
        state_d     = state_q;
        freq_d      = freq_q;
        f_start_d   = f_start_q;
        f_step_d    = f_step_q;
        cur_freq_d  = cur_freq_q;
        n_steps_d   = n_steps_q;
        step_cnt_d  = step_cnt_q;
        dwell_d     = dwell_q;
        dwell_cnt_d = dwell_cnt_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        wr_d        = 1'b0;
        done_d      = 1'b0;
        // Remember that the host took the port while the sweep was waiting.
        defer_d     = sweep_req && host_grant;

        if (host_grant) begin
            wr_d    = 1'b1;
            waddr_d = host_waddr;
            wdata_d = host_wdata;
        end else if (sweep_grant) begin
            wr_d    = 1'b1;
            waddr_d = FREQ_ADDR;
            wdata_d = freq_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    if (n_steps == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        f_start_d  = f_start;
                        f_step_d   = f_step;
                        n_steps_d  = n_steps;
                        // A zero dwell behaves as a one-cycle hold.
                        dwell_d    = (dwell == 16'd0) ? 16'd1 : dwell;
                        freq_d     = f_start;
                        step_cnt_d = 16'd0;
                        state_d    = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (sweep_grant) begin
                    cur_freq_d  = freq_q;
                    dwell_cnt_d = dwell_q;
                    state_d     = S_DWELL;
                end
            end
            S_DWELL: begin
                if (dwell_cnt_q != 16'd0) begin
                    dwell_cnt_d = dwell_cnt_q - 16'd1;
                end
`ifdef DDS_SWEEP_LOOP_EN
                // Each pass ends by reloading f_start; the sweep never idles.
                if (dwell_cnt_q == 16'd1) begin
                    state_d = S_WRITE;
                    if (last_step) begin
                        done_d     = 1'b1;
                        freq_d     = f_start_q;
                        step_cnt_d = 16'd0;
                    end else begin
                        freq_d     = freq_q + f_step_q;
                        step_cnt_d = step_cnt_q + 16'd1;
                    end
                end
`else
                // Intermediate steps request the port as the dwell expires so
                // writes are dwell+1 apart; the last step lets the counter sit
                // at zero for one cycle before reporting completion.
                if ((dwell_cnt_q == 16'd1) && !last_step) begin
                    freq_d     = freq_q + f_step_q;
                    step_cnt_d = step_cnt_q + 16'd1;
                    state_d    = S_WRITE;
                end else if (dwell_cnt_q == 16'd0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort: back to idle, any pending sweep write is dropped, no done.
        if (stop) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            freq_q      <= '0;
            f_start_q   <= '0;
            f_step_q    <= '0;
            cur_freq_q  <= '0;
            n_steps_q   <= '0;
            step_cnt_q  <= '0;
            dwell_q     <= '0;
            dwell_cnt_q <= '0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            done_q      <= 1'b0;
            defer_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            freq_q      <= freq_d;
            f_start_q   <= f_start_d;
            f_step_q    <= f_step_d;
            cur_freq_q  <= cur_freq_d;
            n_steps_q   <= n_steps_d;
            step_cnt_q  <= step_cnt_d;
            dwell_q     <= dwell_d;
            dwell_cnt_q <= dwell_cnt_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            wr_q        <= wr_d;
            done_q      <= done_d;
            defer_q     <= defer_d;
        end
    end

    assign wr       = wr_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;
    assign done     = done_q;
    assign cur_freq = cur_freq_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: timestamp-based reference model of the sweep
// schedule and port sharing, per-cycle output compare, directed scenarios
// with hand-computed literals, then randomized traffic.
module tb_dds_sweep_ctrl;

  localparam logic [15:0] FREQ = 16'h0020;
  localparam int NEVER = 32'h7fffffff;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // dut signals
  logic        start = 0, stop = 0, host_wr = 0;
  logic [15:0] f_start = 0, f_step = 0, n_steps = 0, dwell = 0;
  logic [15:0] host_waddr = 0, host_wdata = 0;
  logic        host_ready, wr, busy, done;
  logic [15:0] waddr, wdata, cur_freq;

  dds_sweep_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .f_start(f_start), .f_step(f_step), .n_steps(n_steps), .dwell(dwell),
    .host_wr(host_wr), .host_waddr(host_waddr), .host_wdata(host_wdata),
    .host_ready(host_ready), .wr(wr), .waddr(waddr), .wdata(wdata),
    .busy(busy), .done(done), .cur_freq(cur_freq)
  );

  // scoreboard bookkeeping
  int n_vec = 0;
  int n_fail = 0;
  int cyc = 0;
  logic chk_en = 0;
  int log_cyc[$];
  logic [15:0] log_addr[$];
  logic [15:0] log_data[$];
  int done_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // reference model: sweep expressed as a list of frequency writes with
  // request timestamps, plus a one-shot deferral flag for host contention
  logic        exp_wr = 0, exp_done = 0, m_busy = 0, m_deferred = 0, m_since_rst = 1;
  logic [15:0] exp_waddr = 0, exp_wdata = 0, exp_cur = 0;
  logic [15:0] m_fs = 0, m_st = 0;
  int m_n = 0, m_d = 1, m_idx = 0, m_req_at = NEVER, m_done_at = NEVER;

  function automatic logic [15:0] freq_at(input int i);
    logic [31:0] t;
    t = 32'(m_fs) + 32'(i) * 32'(m_st);
    return t[15:0];
  endfunction

  function automatic logic model_ready();
    return !(m_busy && !stop && (m_req_at <= cyc) && m_deferred);
  endfunction

  always @(posedge clk or posedge rst) begin
    logic req, hr;
    if (rst) begin
      exp_wr = 0; exp_done = 0; exp_waddr = 0; exp_wdata = 0; exp_cur = 0;
      m_busy = 0; m_deferred = 0; m_req_at = NEVER; m_done_at = NEVER; m_since_rst = 1;
    end else begin
      cyc++;
      req = m_busy && !stop && (m_req_at <= cyc - 1);
      hr = !(req && m_deferred);
      exp_wr = 0;
      exp_done = 0;
      if (stop) begin
        m_busy = 0; m_deferred = 0; m_req_at = NEVER; m_done_at = NEVER;
      end else if (!m_busy) begin
        if (start) begin
          if (n_steps == 0) exp_done = 1;
          else begin
            m_fs = f_start; m_st = f_step; m_n = int'(n_steps);
            m_d = (dwell == 0) ? 1 : int'(dwell);
            m_idx = 0; m_busy = 1; m_req_at = cyc; m_done_at = NEVER; m_deferred = 0;
          end
        end
      end else if (m_done_at == cyc) begin
        exp_done = 1;
        m_done_at = NEVER;
`ifndef DDS_SWEEP_LOOP_EN
        m_busy = 0;
`endif
      end
      if (host_wr && hr) begin
        exp_wr = 1; exp_waddr = host_waddr; exp_wdata = host_wdata;
        m_deferred = req;
      end else if (req) begin
        exp_wr = 1; exp_waddr = FREQ; exp_wdata = freq_at(m_idx); exp_cur = exp_wdata;
        m_deferred = 0;
        if (m_idx == m_n - 1) begin
`ifdef DDS_SWEEP_LOOP_EN
          m_done_at = cyc + m_d; m_idx = 0; m_req_at = cyc + m_d;
`else
          m_done_at = cyc + m_d + 1; m_req_at = NEVER;
`endif
        end else begin
          m_idx++; m_req_at = cyc + m_d;
        end
      end
      if (exp_wr) m_since_rst = 0;
    end
  end

  // per-cycle compare, away from the active edge
  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      chk("wr", wr, exp_wr);
      if (exp_wr || m_since_rst) begin
        chk("waddr", waddr, exp_waddr);
        chk("wdata", wdata, exp_wdata);
      end
      chk("busy", busy, m_busy);
      chk("done", done, exp_done);
      chk("cur_freq", cur_freq, exp_cur);
      chk("host_ready", host_ready, model_ready());
      if (wr) begin
        log_cyc.push_back(cyc); log_addr.push_back(waddr); log_data.push_back(wdata);
      end
      if (done) done_cyc.push_back(cyc);
    end
  end

  // driver tasks
  task automatic launch(input logic [15:0] fs, input logic [15:0] st,
                        input logic [15:0] n, input logic [15:0] dw, output int ks);
    @(negedge clk);
    f_start = fs; f_step = st; n_steps = n; dwell = dw; start = 1;
    ks = cyc + 1;
    log_cyc.delete(); log_addr.delete(); log_data.delete(); done_cyc.delete();
    @(negedge clk);
    start = 0;
    f_start = 16'($urandom); f_step = 16'($urandom);
    n_steps = 16'($urandom); dwell = 16'($urandom);
  endtask

  task automatic halt();
    @(negedge clk); stop = 1; host_wr = 0;
    @(negedge clk); stop = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_log(input string nm, input int i, input int ks, input int rel,
                         input logic [15:0] a, input logic [15:0] d);
    if (i < log_cyc.size()) begin
      chk({nm, "_cycle"}, log_cyc[i] - ks, rel);
      chk({nm, "_addr"}, log_addr[i], a);
      chk({nm, "_data"}, log_data[i], d);
    end else begin
      chk({nm, "_present"}, log_cyc.size(), i + 1);
    end
  endtask

  task automatic chk_done_at(input string nm, input int ks, input int rel);
    if (done_cyc.size() > 0) chk(nm, done_cyc[0] - ks, rel);
    else chk({nm, "_present"}, done_cyc.size(), 1);
  endtask

  initial begin
    int ks;
    logic last_ready;
    #2 rst = 1;
    chk_en = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);

    // basic sweep
    launch(16'h0002, 16'h0010, 16'd3, 16'd4, ks);
    repeat (20) @(negedge clk);
    chk_log("basic_w0", 0, ks, 1, FREQ, 16'h0002);
    chk_log("basic_w1", 1, ks, 6, FREQ, 16'h0012);
    chk_log("basic_w2", 2, ks, 11, FREQ, 16'h0022);
`ifdef DDS_SWEEP_LOOP_EN
    chk_log("basic_w3", 3, ks, 16, FREQ, 16'h0002);
    chk_done_at("basic_done", ks, 15);
`else
    chk("basic_nwr", log_cyc.size(), 3);
    chk_done_at("basic_done", ks, 16);
    chk("basic_cur", cur_freq, 16'h0022);
`endif
    halt();

    // wrap at 2^16
    launch(16'hFFF0, 16'h0020, 16'd2, 16'd0, ks);
    repeat (8) @(negedge clk);
    chk_log("wrap_w0", 0, ks, 1, FREQ, 16'hFFF0);
    chk_log("wrap_w1", 1, ks, 3, FREQ, 16'h0010);
    halt();

    // contention: host holds a request across the first sweep write
    launch(16'h0002, 16'h0010, 16'd3, 16'd4, ks);
    host_wr = 1; host_waddr = 16'h0030; host_wdata = 16'h000F;
    @(negedge clk);
    #2 chk("cont_ready_low", host_ready, 1'b0);
    @(negedge clk);
    @(negedge clk);
    host_wr = 0;
    repeat (20) @(negedge clk);
    chk_log("cont_h0", 0, ks, 1, 16'h0030, 16'h000F);
    chk_log("cont_s0", 1, ks, 2, FREQ, 16'h0002);
    chk_log("cont_h1", 2, ks, 3, 16'h0030, 16'h000F);
    chk_log("cont_s1", 3, ks, 7, FREQ, 16'h0012);
`ifdef DDS_SWEEP_LOOP_EN
    chk_done_at("cont_done", ks, 16);
`else
    chk_done_at("cont_done", ks, 17);
`endif
    halt();

    // stop in mid-dwell of step 1
    launch(16'h0002, 16'h0010, 16'd3, 16'd4, ks);
    repeat (6) @(negedge clk);
    stop = 1;
    @(negedge clk);
    stop = 0;
    #2 chk("stop_busy", busy, 1'b0);
    repeat (15) @(negedge clk);
    chk("stop_nwr", log_cyc.size(), 2);
    chk("stop_ndone", done_cyc.size(), 0);

    // n_steps = 0
    launch(16'h1234, 16'h0001, 16'd0, 16'd3, ks);
    repeat (4) @(negedge clk);
    chk("zero_nwr", log_cyc.size(), 0);
    chk_done_at("zero_done", ks, 0);

    // async reset while a sweep write is on the port
    launch(16'h0002, 16'h0010, 16'd3, 16'd4, ks);
    repeat (6) @(negedge clk);
    rst = 1;
    #2;
    chk("rst_wr", wr, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_waddr", waddr, 16'h0000);
    chk("rst_wdata", wdata, 16'h0000);
    chk("rst_cur", cur_freq, 16'h0000);
    chk("rst_ready", host_ready, 1'b1);
    @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);

    // randomized traffic
    last_ready = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 12) == 0);
      stop = ($urandom_range(0, 80) == 0);
      f_start = 16'($urandom); f_step = 16'($urandom);
      n_steps = 16'($urandom_range(0, 4)); dwell = 16'($urandom_range(0, 4));
      if (!(host_wr && !last_ready)) begin
        host_wr = ($urandom_range(0, 3) == 0);
        host_waddr = 16'($urandom); host_wdata = 16'($urandom);
      end
      #2 last_ready = host_ready;
    end
    halt();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
